fma_issue: RTL and testbench

Initiator side of the FMA port: accepts tagged multiply-add requests on a valid/ready stream, drives the fixed-latency FMA unit (operands, mode, clock enable), tracks in-flight tags in a shadow pipeline, and returns results in order on a valid/ready output stream. It sits between the shader-core operand collector and the FMA. It holds back-pressure by freezing the FMA pipeline via `clken` rather than dropping results.

---
 rtl/fma_issue.sv | 136 +++++++++++++
 tb/tb_fma_issue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_issue.sv
// Issue/return wrapper around a fixed-latency FMA: shadow tag pipeline plus in-order result FIFO.
// Optional `FMA_ISSUE_PERF_EN builds the issued/stall performance counters; otherwise they read 0.
module fma_issue #(
    parameter int FW    = 32,
    parameter int LAT   = 21,
    parameter int TAGW  = 6,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FW-1:0]   in_a,
    input  logic [FW-1:0]   in_b,
    input  logic [FW-1:0]   in_c,
    input  logic            in_mode,
    input  logic [TAGW-1:0] in_tag,
    output logic [FW-1:0]   fma_a,
    output logic [FW-1:0]   fma_b,
    output logic [FW-1:0]   fma_c,
    output logic            fma_mode,
    output logic            fma_clken,
    input  logic [FW-1:0]   fma_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FW-1:0]   out_data,
    output logic [TAGW-1:0] out_tag,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall
);
    localparam int AW = $clog2(DEPTH);

    logic [LAT-1:0]  vld_p;
    logic [TAGW-1:0] tag_p [LAT];
    logic [FW-1:0]   mem_d [DEPTH];
    logic [TAGW-1:0] mem_t [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr, rd_nxt;
    logic [AW:0]     count;
    logic            vld_last, full, accept, push, pop;

    assign fma_a    = in_a;
    assign fma_b    = in_b;
    assign fma_c    = in_c;
    assign fma_mode = in_mode;

    assign vld_last  = vld_p[LAT-1];
    assign full      = (count == (AW+1)'(DEPTH));
    // Conservative stall: a pop in the same cycle does not release it.
    assign fma_clken = !(vld_last && full);
    assign in_ready  = fma_clken;
    assign accept    = in_valid && in_ready;
    assign push      = fma_clken && vld_last;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign rd_nxt    = rd_ptr + AW'(1);

    // Shadow pipeline stage boundary: valid/tag advance in lockstep with the FMA.
    always_ff @(posedge clk) begin
        if (!rstn)
            vld_p <= '0;
        else if (fma_clken)
            vld_p <= {vld_p[LAT-2:0], accept};
    end

    always_ff @(posedge clk) begin
        if (fma_clken) begin
            tag_p[0] <= in_tag;
            for (int i = 1; i < LAT; i++)
                tag_p[i] <= tag_p[i-1];
        end
    end

    // Result FIFO boundary: storage, pointers and registered head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wr_ptr] <= fma_out;
            mem_t[wr_ptr] <= tag_p[LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_nxt;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Head mirrors mem[rd_ptr]; the write bypass covers a push into an empty or draining FIFO.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_data <= '0;
            out_tag  <= '0;
        end else if (pop) begin
            if (count > (AW+1)'(1)) begin
                out_data <= mem_d[rd_nxt];
                out_tag  <= mem_t[rd_nxt];
            end else if (push) begin
                out_data <= fma_out;
                out_tag  <= tag_p[LAT-1];
            end
        end else if (!out_valid && push) begin
            out_data <= fma_out;
            out_tag  <= tag_p[LAT-1];
        end
    end

`ifdef FMA_ISSUE_PERF_EN
    logic [31:0] issued_q, stall_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (accept)
                issued_q <= issued_q + 32'd1;
            if (!fma_clken)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`else
    assign perf_issued = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_fma_issue.sv
// Scoreboard bench for fma_issue: behavioural FMA, directed plan cases, randomized traffic.
module tb_fma_issue;
    localparam int FW = 32, LAT = 21, TAGW = 6, DEPTH = 4;

    logic            clk = 0;
    logic            rstn = 0;
    logic            in_valid = 0, in_ready;
    logic [FW-1:0]   in_a = 0, in_b = 0, in_c = 0;
    logic            in_mode = 0;
    logic [TAGW-1:0] in_tag = 0;
    logic [FW-1:0]   fma_a, fma_b, fma_c, fma_out;
    logic            fma_mode, fma_clken;
    logic            out_valid, out_ready = 1;
    logic [FW-1:0]   out_data;
    logic [TAGW-1:0] out_tag;
    logic [31:0]     perf_issued, perf_stall;

    fma_issue #(.FW(FW), .LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode), .in_tag(in_tag),
        .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_mode(fma_mode),
        .fma_clken(fma_clken), .fma_out(fma_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .perf_issued(perf_issued), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    // Behavioural FMA with clock-enabled pipeline of LAT stages.
    logic [FW-1:0] fp [LAT];
    initial for (int i = 0; i < LAT; i++) fp[i] = '0;
    always @(posedge clk) begin
        if (fma_clken) begin
            fp[0] <= fma_mode ? fma_a * fma_b + fma_c : fma_a * fma_b - fma_c;
            for (int i = 1; i < LAT; i++) fp[i] <= fp[i-1];
        end
    end
    assign fma_out = fp[LAT-1];

    typedef struct {
        logic [FW-1:0]   d;
        logic [TAGW-1:0] t;
        int              cyc;
        bit              lat;
    } exp_t;

    exp_t sbq[$];
    int   nchk = 0, nerr = 0;
    int   cyc = 0;
    int   acc_cnt = 0, stall_cnt = 0;
    bit   lat_chk = 0, bp_mode = 0, rnd_done = 0;
    int   bp_acc0 = -1, bp_stall0 = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Monitor: captures accepted requests into the scoreboard and checks every result handshake.
    always @(negedge clk) begin
        if (!rstn) begin
            sbq.delete();
            acc_cnt   = 0;
            stall_cnt = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_t e;
                e.d   = in_mode ? in_a * in_b + in_c : in_a * in_b - in_c;
                e.t   = in_tag;
                e.cyc = cyc;
                e.lat = lat_chk;
                sbq.push_back(e);
                acc_cnt++;
                if (bp_mode && bp_acc0 < 0) bp_acc0 = cyc;
            end
            if (!fma_clken) begin
                stall_cnt++;
                if (bp_mode && bp_stall0 < 0) bp_stall0 = cyc;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL spurious_out: got out_valid=1 tag=%0d, required no result", out_tag);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_tag", 64'(out_tag), 64'(e.t));
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(LAT + 1));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic [FW-1:0] c,
                         input logic m, input logic [TAGW-1:0] t);
        int n = 0;
        in_valid = 1; in_a = a; in_b = b; in_c = c; in_mode = m; in_tag = t;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) begin
            nchk++;
            nerr++;
            $display("FAIL issue_timeout: got in_ready=0 for %0d cycles, required accept", n);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sbq.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL %s: got %0d results outstanding, required 0", name, sbq.size());
        end
    endtask

    task automatic check_counters(input string name, input logic [31:0] iss, input logic [31:0] stl);
`ifdef FMA_ISSUE_PERF_EN
        chk({name, "_perf_issued"}, 64'(perf_issued), 64'(iss));
        chk({name, "_perf_stall"}, 64'(perf_stall), 64'(stl));
`else
        chk({name, "_perf_issued"}, 64'(perf_issued), 64'(0));
        chk({name, "_perf_stall"}, 64'(perf_stall), 64'(0));
`endif
    endtask

    task automatic random_traffic(input int nops);
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < nops; i++) begin
                    logic [FW-1:0] a, b, c;
                    a = (i % 17 == 0) ? '1 : FW'($urandom);
                    b = (i % 13 == 0) ? '1 : FW'($urandom);
                    c = FW'($urandom);
                    issue(a, b, c, 1'($urandom), TAGW'($urandom));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1;
        wait_drain("random_drain");
    endtask

    initial begin
        idle(3);
        rstn = 1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_fma_clken", 64'(fma_clken), 64'(1));
        check_counters("rst", 32'd0, 32'd0);
        @(posedge clk);
        #1;

        // Back-pressure: 30 ops with the consumer stalled, then released.
        bp_mode = 1;
        out_ready = 0;
        fork
            for (int i = 0; i < 30; i++) issue(FW'(i + 1), FW'(3 * i + 7), FW'(i), 1'(i % 2), TAGW'(i));
            begin
                idle(80);
                chk("bp_in_ready_stalled", 64'(in_ready), 64'(0));
                chk("bp_clken_stalled", 64'(fma_clken), 64'(0));
                chk("bp_out_valid_stalled", 64'(out_valid), 64'(1));
                out_ready = 1;
            end
        join
        wait_drain("bp_drain");
        bp_mode = 0;
        chk("bp_stall_onset", 64'(bp_stall0 - bp_acc0), 64'(LAT + 4));
        @(negedge clk);
        check_counters("bp", 32'd30, 32'(stall_cnt));
        @(posedge clk);
        #1;

        // Single add with fixed latency.
        lat_chk = 1;
        issue(2, 3, 1, 1, 5);
        wait_drain("single_drain");

        // Back-to-back mixed modes.
        issue(2, 3, 1, 0, 1);
        issue(4, 5, 6, 1, 2);
        issue(0, 9, 9, 0, 3);
        wait_drain("b2b_drain");

        // Alternating-cycle issue.
        for (int i = 0; i < 8; i++) begin
            issue(FW'($urandom), FW'($urandom), FW'($urandom), 1'($urandom), TAGW'(i + 10));
            idle(1);
        end
        wait_drain("bubble_drain");
        lat_chk = 0;

        random_traffic(300);

        // Reset with work in flight.
        for (int i = 0; i < 10; i++) issue(FW'($urandom), FW'($urandom), FW'(i), 1, TAGW'(i));
        rstn = 0;
        @(posedge clk);
        #1;
        rstn = 1;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_out_data", 64'(out_data), 64'(0));
        chk("mid_rst_out_tag", 64'(out_tag), 64'(0));
        check_counters("mid_rst", 32'd0, 32'd0);
        for (int i = 0; i < 40; i++) begin
            chk("mid_rst_quiet", 64'(out_valid), 64'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        random_traffic(100);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, required finish");
        $fatal(1, "timeout");
    end
endmodule
